// File: rtl/counter_sweep_ctrl_amisha.sv
// counter_sweep_ctrl_amisha: sequencer driving a universal binary counter through clear, load and paced sweeps.
module counter_sweep_ctrl_amisha #(
  parameter int N = 8,
  parameter int PW = 4
) (
  input  logic          clk_amisha,
  input  logic          reset_amisha,
  input  logic          start_amisha,
  input  logic          stop_amisha,
  input  logic [1:0]    mode_amisha,
  input  logic [N-1:0]  init_amisha,
  input  logic [PW-1:0] div_amisha,
  input  logic          max_tick_amisha,
  input  logic          min_tick_amisha,
  output logic          syn_clr_amisha,
  output logic          load_amisha,
  output logic          en_amisha,
  output logic          up_amisha,
  output logic [N-1:0]  d_amisha,
  output logic          busy_amisha,
  output logic          done_amisha,
  output logic [7:0]    sweeps_amisha
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [1:0] mode;
  logic [N-1:0] init;
  logic [PW-1:0] div, pre;
  logic dir, run, tick, go, wrap, last;
  assign run = state == RUN;
  assign tick = run & (pre == div);
  assign go = tick & ~stop_amisha;
  // wrap covers both a wrap-around (modes 00/01) and a reversal (mode 10)
  always_comb begin
    wrap = go & (mode == 2'b00 ? max_tick_amisha :
                 mode == 2'b01 ? min_tick_amisha :
                 mode == 2'b10 ? (dir ? max_tick_amisha : min_tick_amisha) : 1'b0);
    last = go & (mode == 2'b11) & max_tick_amisha;
    en_amisha = go & ~last;
    up_amisha = run & (mode == 2'b01 ? 1'b0 : mode == 2'b10 ? dir ^ wrap : 1'b1);
    syn_clr_amisha = state == CLEAR;
    load_amisha = state == LOAD;
    busy_amisha = state == CLEAR || state == LOAD || state == RUN;
    done_amisha = state == DONE;
    d_amisha = init;
  end
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      state <= IDLE;
      mode <= '0;
      init <= '0;
      div <= '0;
      pre <= '0;
      dir <= 1'b1;
      sweeps_amisha <= '0;
    end else begin
      case (state)
        IDLE: if (start_amisha) begin
          mode <= mode_amisha;
          init <= init_amisha;
          div <= div_amisha;
          pre <= '0;
          sweeps_amisha <= '0;
          dir <= mode_amisha != 2'b01;
          state <= CLEAR;
        end
        CLEAR: state <= LOAD;
        LOAD: state <= RUN;
        RUN: if (stop_amisha) state <= DONE;
        else begin
          pre <= tick ? '0 : pre + 1'b1;
          if (wrap && sweeps_amisha != 8'hFF) sweeps_amisha <= sweeps_amisha + 8'd1;
          if (wrap && mode == 2'b10) dir <= ~dir;
          if (last) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
